if2id_fetch: RTL and testbench
==============================

# if2id_fetch

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined MIPS core, directly upstream of the ID stage and the ID/EX register. Holds the PC and issues the instruction-memory address. Registers the fetched instruction and PC+1 toward ID. Detects load-use hazards (stall) and executes EX-resolved branch/jump redirects (flush), and keeps saturating stall/flush event counters.

## Interface
- n, 16, datapath/instruction/PC width
- RESET_PC, 0, PC value loaded on reset
- NOP, 16'h0000, instruction injected into IF/ID on flush/reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  n  instruction-memory address; equals PC register (combinational from reg)
- imem_data  in  n  instruction word at imem_addr; combinational memory read, same cycle
- ex_memread  in  1  instruction currently in EX is a load
- ex_load_rt  in  3  destination register of the load in EX
- br_taken  in  1  EX resolved a taken branch/jump this cycle
- br_target  in  n  redirect PC, valid when br_taken
- ID_PC_adder_out  out  n  registered PC+1 of the instruction in ID
- ID_inst  out  n  registered instruction in ID
- ID_valid  out  1  ID holds a real (non-injected) instruction
- id_bubble  out  1  combinational; ID/EX must load zeros for all control fields next edge
- stall_cnt  out  16  saturating count of stall cycles
- flush_cnt  out  16  saturating count of flush events

## Operation
- Field decode of ID_inst: rs = ID_inst[10:8], rt = ID_inst[7:5]; opcode = ID_inst[15:11].
- Hazard: hz = ex_memread & ID_valid & (ex_load_rt == rs | ex_load_rt == rt). Register 0 is not excluded.
- Each cycle the block takes one of three actions, in priority order:
  - REDIRECT (br_taken=1):
    - PC <= br_target.
    - IF/ID <= {PC_adder=0, inst=NOP, valid=0}.
    - id_bubble=1.
    - flush_cnt++.
    - Overrides hz in the same cycle.
  - STALL (hz=1, br_taken=0):
    - PC holds; IF/ID holds.
    - id_bubble=1.
    - stall_cnt++.
  - NORMAL:
    - PC <= PC+1, modulo 2^n; 16'hFFFF wraps to 0.
    - IF/ID <= {PC+1, imem_data, 1}.
    - id_bubble=0.
- Counters saturate at 16'hFFFF and never wrap.
- id_bubble is purely combinational from current state and inputs; no registered delay.
- Stall state machine is implicit, with no extra state: a stall persists only while hz holds. With one load in EX, hz lasts exactly one cycle, because next cycle EX holds the bubble (ex_memread=0).

## Timing
- Reset (rst=1 at edge):
  - PC=RESET_PC.
  - ID_PC_adder_out=0, ID_inst=NOP, ID_valid=0.
  - stall_cnt=0, flush_cnt=0.
  - imem_addr=RESET_PC.
  - id_bubble evaluates to 0 while ID_valid=0 and br_taken=0.
- rst dominates br_taken and hz; reset mid-stall or mid-redirect discards the pending action.
- Fetch latency: instruction at address A appears on ID_inst one edge after imem_addr=A, in NORMAL.
- Redirect penalty:
  - Instruction fetched in the redirect cycle is discarded.
  - Target is presented on imem_addr the cycle after the edge.
  - Target appears in ID two edges after br_taken.
- Load-use: exactly one bubble per dependent pair; the dependent instruction remains in ID for 2 cycles.
- br_taken on consecutive cycles: each cycle redirects and counts; the last target wins.
- ID_valid=0 suppresses hz, so the injected NOP never causes a stall.

## Test plan
- Reset then free-run, imem_data = address+16'h1000:
  - After rst falls, imem_addr steps 0,1,2,…
  - ID_inst at cycle k = 16'h1000+(k−1); ID_PC_adder_out = k.
  - id_bubble=0 throughout.
- Load-use:
  - Stimulus: ID_inst rs=3, ex_memread=1, ex_load_rt=3 for one cycle.
  - Response: id_bubble=1; PC and ID_inst unchanged over that edge; stall_cnt=1; fetch resumes next cycle.
  - Repeat with ex_load_rt=4, rs=3, rt=5: no stall.
- Branch:
  - Stimulus: br_taken=1, br_target=16'h0040 while PC=16'h0007.
  - Response next edge: imem_addr=16'h0040, ID_inst=NOP, ID_valid=0, flush_cnt=1.
  - Following edge: ID_PC_adder_out=16'h0041.
- Branch and hazard in the same cycle: redirect wins; flush_cnt=1, stall_cnt=0.
- Wrap and saturation:
  - RESET_PC=16'hFFFE: imem_addr runs FFFE, FFFF, 0000.
  - Hold hz for 70000 cycles: stall_cnt stops at 16'hFFFF.
- Reset mid-stall: assert rst while hz=1 → all outputs return to reset values next edge.

Source files
------------

// File: rtl/if2id_fetch_if.sv
// rtl/if2id_fetch_if.sv - fetch-stage bundle: imem port, EX hazard/redirect inputs, IF/ID outputs
interface if2id_fetch_if #(
   parameter int n = 16
) ();
   logic [n-1:0] imem_addr;
   logic [n-1:0] imem_data;
   logic         ex_memread;
   logic [2:0]   ex_load_rt;
   logic         br_taken;
   logic [n-1:0] br_target;
   logic [n-1:0] ID_PC_adder_out;
   logic [n-1:0] ID_inst;
   logic         ID_valid;
   logic         id_bubble;
   logic [15:0]  stall_cnt;
   logic [15:0]  flush_cnt;

   modport master (
      output imem_addr, ID_PC_adder_out, ID_inst, ID_valid, id_bubble, stall_cnt, flush_cnt,
      input  imem_data, ex_memread, ex_load_rt, br_taken, br_target
   );

   modport slave (
      input  imem_addr, ID_PC_adder_out, ID_inst, ID_valid, id_bubble, stall_cnt, flush_cnt,
      output imem_data, ex_memread, ex_load_rt, br_taken, br_target
   );
endinterface

// File: rtl/if2id_fetch.sv
// rtl/if2id_fetch.sv - PC, instruction fetch and IF/ID register with load-use stall and redirect flush
module if2id_fetch #(
   parameter int           n        = 16,
   parameter logic [n-1:0] RESET_PC = '0,
   parameter logic [n-1:0] NOP      = '0
) (
   input logic           clk,
   input logic           rst,
   if2id_fetch_if.master bus
);
   logic [n-1:0] pc;
   logic [n-1:0] pc_plus1;
   logic [n-1:0] id_pc;
   logic [n-1:0] id_inst;
   logic         id_valid;
   logic [15:0]  stall_cnt;
   logic [15:0]  flush_cnt;
   logic [2:0]   rs;
   logic [2:0]   rt;
   logic         hz;

   assign pc_plus1 = pc + 1'b1;
   assign rs       = id_inst[10:8];
   assign rt       = id_inst[7:5];

   // An injected NOP (id_valid=0) never matches, so a flush cannot trigger a stall.
   assign hz = bus.ex_memread & id_valid &
               ((bus.ex_load_rt == rs) | (bus.ex_load_rt == rt));

   assign bus.imem_addr       = pc;
   assign bus.ID_PC_adder_out = id_pc;
   assign bus.ID_inst         = id_inst;
   assign bus.ID_valid        = id_valid;
   assign bus.id_bubble       = bus.br_taken | hz;
   assign bus.stall_cnt       = stall_cnt;
   assign bus.flush_cnt       = flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         id_pc     <= '0;
         id_inst   <= NOP;
         id_valid  <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (bus.br_taken) begin
         pc        <= bus.br_target;
         id_pc     <= '0;
         id_inst   <= NOP;
         id_valid  <= 1'b0;
         if (flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end else if (hz) begin
         if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end else begin
         pc       <= pc_plus1;
         id_pc    <= pc_plus1;
         id_inst  <= bus.imem_data;
         id_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if2id_fetch.sv
// tb/tb_if2id_fetch.sv - randomized and directed bench for if2id_fetch against a behavioural model
module tb_if2id_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_memread = 1'b0;
   logic [2:0]  ex_load_rt = 3'd0;
   logic        br_taken = 1'b0;
   logic [15:0] br_target = 16'd0;
   bit          mem_mode = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] fmem(input logic [15:0] a, input bit mode);
      return mode ? ((a * 16'h9E37) ^ 16'h5A5A) : (a + 16'h1000);
   endfunction

   if2id_fetch_if #(.n(16)) ifa ();
   if2id_fetch_if #(.n(16)) ifb ();

   assign ifa.ex_memread = ex_memread;
   assign ifa.ex_load_rt = ex_load_rt;
   assign ifa.br_taken   = br_taken;
   assign ifa.br_target  = br_target;
   assign ifa.imem_data  = fmem(ifa.imem_addr, mem_mode);
   assign ifb.ex_memread = ex_memread;
   assign ifb.ex_load_rt = ex_load_rt;
   assign ifb.br_taken   = br_taken;
   assign ifb.br_target  = br_target;
   assign ifb.imem_data  = fmem(ifb.imem_addr, mem_mode);

   if2id_fetch #(.n(16), .RESET_PC(16'h0000), .NOP(16'h0000)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   if2id_fetch #(.n(16), .RESET_PC(16'hFFFE), .NOP(16'h0000)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // Behavioural model: one entry per DUT instance.
   bit [15:0] m_rpc [2] = '{16'h0000, 16'hFFFE};
   bit [15:0] m_pc [2];
   bit [15:0] m_idpc [2];
   bit [15:0] m_inst [2];
   bit        m_valid [2];
   int        m_stall [2];
   int        m_flush [2];
   bit        model_ok = 1'b0;

   function automatic bit m_hz(input int i);
      int rs, rt;
      rs = int'(m_inst[i] >> 8) % 8;
      rt = int'(m_inst[i] >> 5) % 8;
      return ex_memread && m_valid[i] && (int'(ex_load_rt) == rs || int'(ex_load_rt) == rt);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_pc[i] = m_rpc[i]; m_idpc[i] = 0; m_inst[i] = 0; m_valid[i] = 0;
            m_stall[i] = 0; m_flush[i] = 0;
         end else if (br_taken) begin
            m_pc[i] = br_target; m_idpc[i] = 0; m_inst[i] = 0; m_valid[i] = 0;
            m_flush[i] = (m_flush[i] >= 65535) ? 65535 : m_flush[i] + 1;
         end else if (m_hz(i)) begin
            m_stall[i] = (m_stall[i] >= 65535) ? 65535 : m_stall[i] + 1;
         end else begin
            m_inst[i]  = fmem(m_pc[i], mem_mode);
            m_idpc[i]  = (m_pc[i] + 1) % 65536;
            m_pc[i]    = m_idpc[i];
            m_valid[i] = 1;
         end
      end
      if (rst) model_ok = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model(input int i, input logic [15:0] addr, input logic [15:0] idpc,
                            input logic [15:0] inst, input logic valid, input logic bub,
                            input logic [15:0] sc, input logic [15:0] fc);
      chk($sformatf("m%0d imem_addr", i), {16'd0, addr}, {16'd0, m_pc[i]});
      chk($sformatf("m%0d ID_PC_adder_out", i), {16'd0, idpc}, {16'd0, m_idpc[i]});
      chk($sformatf("m%0d ID_inst", i), {16'd0, inst}, {16'd0, m_inst[i]});
      chk($sformatf("m%0d ID_valid", i), {31'd0, valid}, {31'd0, m_valid[i]});
      chk($sformatf("m%0d id_bubble", i), {31'd0, bub}, {31'd0, (br_taken || m_hz(i))});
      chk($sformatf("m%0d stall_cnt", i), {16'd0, sc}, m_stall[i]);
      chk($sformatf("m%0d flush_cnt", i), {16'd0, fc}, m_flush[i]);
   endtask

   always @(negedge clk) begin
      if (model_ok && !rst) begin
         cmp_model(0, ifa.imem_addr, ifa.ID_PC_adder_out, ifa.ID_inst, ifa.ID_valid,
                   ifa.id_bubble, ifa.stall_cnt, ifa.flush_cnt);
         cmp_model(1, ifb.imem_addr, ifb.ID_PC_adder_out, ifb.ID_inst, ifb.ID_valid,
                   ifb.id_bubble, ifb.stall_cnt, ifb.flush_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic branch_to(input logic [15:0] t);
      br_taken = 1'b1; br_target = t;
      tick();
      br_taken = 1'b0;
   endtask

   initial begin
      logic [15:0] eb;
      tick(); tick();
      chk("rst imem_addr", ifa.imem_addr, 16'h0000);
      chk("rst imem_addr b", ifb.imem_addr, 16'hFFFE);
      chk("rst ID_inst", ifa.ID_inst, 16'h0000);
      chk("rst ID_PC", ifa.ID_PC_adder_out, 16'h0000);
      chk("rst ID_valid", ifa.ID_valid, 1'b0);
      chk("rst counters", {ifa.stall_cnt, ifa.flush_cnt}, 32'd0);
      chk("rst id_bubble", ifa.id_bubble, 1'b0);
      rst = 1'b0;

      // Free run, then wrap on the FFFE instance.
      for (int k = 1; k <= 7; k++) begin
         tick();
         eb = 16'hFFFE + k[15:0];
         chk("run imem_addr", ifa.imem_addr, k);
         chk("run ID_inst", ifa.ID_inst, 32'h1000 + k - 1);
         chk("run ID_PC", ifa.ID_PC_adder_out, k);
         chk("run id_bubble", ifa.id_bubble, 1'b0);
         chk("wrap imem_addr b", ifb.imem_addr, eb);
      end

      branch_to(16'h0040);
      chk("br imem_addr", ifa.imem_addr, 16'h0040);
      chk("br ID_inst", ifa.ID_inst, 16'h0000);
      chk("br ID_valid", ifa.ID_valid, 1'b0);
      chk("br flush_cnt", ifa.flush_cnt, 16'd1);
      tick();
      chk("br ID_PC", ifa.ID_PC_adder_out, 16'h0041);
      chk("br target inst", ifa.ID_inst, 16'h1040);

      // Load-use on rs=3.
      branch_to(16'h0300);
      tick();
      chk("lu ID_inst", ifa.ID_inst, 16'h1300);
      ex_memread = 1'b1; ex_load_rt = 3'd3;
      #1 chk("lu id_bubble", ifa.id_bubble, 1'b1);
      tick();
      ex_memread = 1'b0;
      chk("lu hold ID_inst", ifa.ID_inst, 16'h1300);
      chk("lu hold imem_addr", ifa.imem_addr, 16'h0301);
      chk("lu stall_cnt", ifa.stall_cnt, 16'd1);
      tick();
      chk("lu resume ID_inst", ifa.ID_inst, 16'h1301);

      // rs=3, rt=5 with load to r4: no stall.
      branch_to(16'h03A0);
      tick();
      chk("ns ID_inst", ifa.ID_inst, 16'h13A0);
      ex_memread = 1'b1; ex_load_rt = 3'd4;
      #1 chk("ns id_bubble", ifa.id_bubble, 1'b0);
      tick();
      ex_memread = 1'b0;
      chk("ns ID_inst next", ifa.ID_inst, 16'h13A1);
      chk("ns stall_cnt", ifa.stall_cnt, 16'd1);
      chk("ns flush_cnt", ifa.flush_cnt, 16'd3);

      // Redirect and hazard together: redirect wins.
      rst = 1'b1; tick(); rst = 1'b0; tick();
      ex_memread = 1'b1; ex_load_rt = 3'd0;
      br_taken = 1'b1; br_target = 16'h0010;
      tick();
      br_taken = 1'b0; ex_memread = 1'b0;
      chk("bh flush_cnt", ifa.flush_cnt, 16'd1);
      chk("bh stall_cnt", ifa.stall_cnt, 16'd0);
      chk("bh imem_addr", ifa.imem_addr, 16'h0010);

      // Reset during a stall.
      tick();
      ex_memread = 1'b1; ex_load_rt = 3'd0;
      #1 chk("rs id_bubble", ifa.id_bubble, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0; ex_memread = 1'b0;
      chk("rs imem_addr", ifa.imem_addr, 16'h0000);
      chk("rs ID_inst", ifa.ID_inst, 16'h0000);
      chk("rs ID_valid", ifa.ID_valid, 1'b0);
      chk("rs counters", {ifa.stall_cnt, ifa.flush_cnt}, 32'd0);

      // Randomized traffic checked by the model every cycle.
      mem_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 149) == 0);
         ex_memread = ($urandom_range(0, 2) == 0);
         ex_load_rt = 3'($urandom_range(0, 7));
         br_taken   = ($urandom_range(0, 7) == 0);
         br_target  = 16'($urandom);
         tick();
      end
      rst = 1'b1; ex_memread = 1'b0; br_taken = 1'b0; mem_mode = 1'b0;
      tick(); rst = 1'b0; tick();

      // Saturation of the stall counter.
      ex_memread = 1'b1; ex_load_rt = 3'd0;
      repeat (65540) tick();
      chk("sat stall_cnt", ifa.stall_cnt, 16'hFFFF);
      chk("sat ID_inst", ifa.ID_inst, 16'h1000);
      ex_memread = 1'b0;
      tick();
      chk("sat resume imem_addr", ifa.imem_addr, 16'h0002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
